uart_stream_tx: RTL

//  Buffered UART transmitter. Accepts bytes on a valid/ready stream, queues them in a FIFO,
//  and serialises them as 8N1 frames (LSB first) on o_uart_tx.
//  It is the TX end of the board UART link and drives the serial pin directly.

---
 rtl/uart_stream_tx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_stream_tx.sv
// uart_stream_tx: buffered UART transmitter.
// Bytes arrive on a valid/ready stream, are queued in a circular FIFO and are
// shifted out LSB first as 8N1 frames on o_uart_tx (idle high).
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit (8E1 framing).
module uart_stream_tx #(
  parameter int unsigned CLK_DIV         = 868,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       rstn,
  input  logic                       clk,
  input  logic                       i_tvalid,
  output logic                       o_tready,
  input  logic [7:0]                 i_tdata,
  output logic                       o_uart_tx,
  output logic                       o_busy,
  output logic [FIFO_DEPTH_LOG2:0]   o_fifo_count
);

  localparam int unsigned AW    = FIFO_DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned BW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  // FIFO storage and pointers (extra MSB is the wrap bit)
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Serialiser state
  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic          baud_last;
  logic [2:0]    bit_cnt;
  logic [2:0]    next_bit;
  logic [7:0]    frame_byte;
  logic          tx;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push      = i_tvalid && !full;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign next_bit  = bit_cnt + 3'd1;

  // Pop decision: start a frame from idle, or chain one directly at the end of STOP
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      case (state)
        IDLE:    pop = 1'b1;
        STOP:    pop = baud_last;
        default: pop = 1'b0;
      endcase
    end
  end

  // FIFO data write; storage needs no reset because emptiness comes from the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= i_tdata;
    end
  end

  // FIFO pointers; push is gated by full before any same-cycle pop is considered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Frame serialiser: every line level is held for exactly CLK_DIV cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      frame_byte <= '0;
      tx         <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) begin
            frame_byte <= head;
            tx         <= 1'b0;
            state      <= START;
          end
        end

        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= frame_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= ^frame_byte;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= next_bit;
              tx      <= frame_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
`endif

        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (pop) begin
              frame_byte <= head;
              tx         <= 1'b0;
              state      <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        default: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign o_uart_tx    = tx;
  assign o_tready     = !full;
  assign o_fifo_count = wr_ptr - rd_ptr;
  assign o_busy       = (state != IDLE) || !empty;

endmodule
